// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states,
// mux selects and the packed control word driven to the datapath.
package multicycle_control_fsm_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEM_ADR = 4'd2,
      S_MEM_RD  = 4'd3,
      S_MEM_WB  = 4'd4,
      S_MEM_WR  = 4'd5,
      S_EXEC    = 4'd6,
      S_ALU_WB  = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDI_EX = 4'd9,
      S_ADDI_WB = 4'd10,
      S_JUMP    = 4'd11
   } state_e;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   localparam logic [1:0] ALUOP_ADD   = 2'd0;
   localparam logic [1:0] ALUOP_SUB   = 2'd1;
   localparam logic [1:0] ALUOP_FUNCT = 2'd2;

   localparam logic [1:0] ALUB_REG    = 2'd0;
   localparam logic [1:0] ALUB_FOUR   = 2'd1;
   localparam logic [1:0] ALUB_SIMM   = 2'd2;
   localparam logic [1:0] ALUB_SIMM_SH = 2'd3;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

   function automatic logic op_supported(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_control_output_decoder.sv
// Moore output map: state encoding -> datapath control word. Unused
// encodings decode to an all-zero (inert) word.
module control_output_decoder
   import multicycle_control_fsm_pkg::*;
(
   input  logic [3:0] state_i,
   output ctrl_t      ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.mem_read  = 1'b1;
            ctrl_o.ir_write  = 1'b1;
            ctrl_o.alu_src_b = ALUB_FOUR;
            ctrl_o.alu_op    = ALUOP_ADD;
            ctrl_o.pc_source = PCSRC_ALU;
            ctrl_o.pc_write  = 1'b1;
         end
         // Speculatively form the branch target while the opcode is decoded.
         S_DECODE: begin
            ctrl_o.alu_src_b = ALUB_SIMM_SH;
            ctrl_o.alu_op    = ALUOP_ADD;
         end
         S_MEM_ADR: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = ALUB_SIMM;
            ctrl_o.alu_op    = ALUOP_ADD;
         end
         S_MEM_RD: begin
            ctrl_o.mem_read = 1'b1;
            ctrl_o.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            ctrl_o.mem_write = 1'b1;
            ctrl_o.i_or_d    = 1'b1;
         end
         S_EXEC: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = ALUB_REG;
            ctrl_o.alu_op    = ALUOP_FUNCT;
         end
         S_ALU_WB: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            ctrl_o.alu_src_a     = 1'b1;
            ctrl_o.alu_src_b     = ALUB_REG;
            ctrl_o.alu_op        = ALUOP_SUB;
            ctrl_o.pc_source     = PCSRC_ALUOUT;
            ctrl_o.pc_write_cond = 1'b1;
         end
         S_ADDI_EX: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = ALUB_SIMM;
            ctrl_o.alu_op    = ALUOP_ADD;
         end
         S_ADDI_WB: begin
            ctrl_o.reg_write = 1'b1;
         end
         S_JUMP: begin
            ctrl_o.pc_source = PCSRC_JUMP;
            ctrl_o.pc_write  = 1'b1;
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS main control FSM: state register and opcode-driven
// sequencing; control outputs come from the state via the output decoder.
module multicycle_control_fsm
   import multicycle_control_fsm_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         opcode,
   output logic [STATE_W-1:0] state,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic               i_or_d,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               mem_to_reg,
   output logic               reg_dst,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_op,
   output logic [1:0]         pc_source,
   output logic               illegal_op
);

   state_e state_q, state_d;
   ctrl_t  ctrl;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d    = S_FETCH;
      illegal_op = 1'b0;
      case (state_q)
         S_FETCH:   state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEM_ADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDI_EX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
            illegal_op = !op_supported(opcode);
         end
         // Opcode comes from the IR, which holds it for the whole instruction.
         S_MEM_ADR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:  state_d = S_MEM_WB;
         S_EXEC:    state_d = S_ALU_WB;
         S_ADDI_EX: state_d = S_ADDI_WB;
         default:   state_d = S_FETCH;
      endcase
   end

   control_output_decoder u_dec (
      .state_i (state_q),
      .ctrl_o  (ctrl)
   );

   assign state         = STATE_W'(state_q);
   assign pc_write      = ctrl.pc_write;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign i_or_d        = ctrl.i_or_d;
   assign mem_read      = ctrl.mem_read;
   assign mem_write     = ctrl.mem_write;
   assign ir_write      = ctrl.ir_write;
   assign mem_to_reg    = ctrl.mem_to_reg;
   assign reg_dst       = ctrl.reg_dst;
   assign reg_write     = ctrl.reg_write;
   assign alu_src_a     = ctrl.alu_src_a;
   assign alu_src_b     = ctrl.alu_src_b;
   assign alu_op        = ctrl.alu_op;
   assign pc_source     = ctrl.pc_source;

endmodule
